bus_decoder_fsm: RTL

- Parametrised, registered successor to the single-cycle memory map decoder.
- Sits between the core's data-port master (load/store unit) and NUM_SLAVES memory-mapped devices: data RAM, GPIO, UART, and others.
- Decodes each request against per-slave address windows and drives a one-hot chip select with a slave-relative word address.
- Waits for a slave acknowledge with a timeout; returns read data, or an error response for unmapped addresses and timeouts.

---
 rtl/bus_decoder_fsm_if.sv | 40 ++++
 rtl/bus_decoder_fsm.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bus_decoder_fsm_if.sv
// ---------------------------------------------------------------------------
// bus_decoder_fsm_if
//   Bundles the data-port master side (m_*) and the chip-select side (s_*)
//   of the registered address decoder.
//   master : view of the load/store unit plus the slave devices (drives
//            m_req/m_we/m_addr/m_wdata and s_rdata/s_ack).
//   slave  : view of the decoder itself (drives m_rdata/m_ack/m_err and
//            s_sel/s_we/s_addr/s_wdata).
// ---------------------------------------------------------------------------
interface bus_decoder_fsm_if #(
   parameter int NUM_SLAVES = 3,
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32
);
   // master request / response
   logic                         m_req;
   logic                         m_we;
   logic [ADDR_W-1:0]            m_addr;
   logic [DATA_W-1:0]            m_wdata;
   logic [DATA_W-1:0]            m_rdata;
   logic                         m_ack;
   logic                         m_err;
   // slave chip-select channel
   logic [NUM_SLAVES-1:0]        s_sel;
   logic                         s_we;
   logic [ADDR_W-1:0]            s_addr;
   logic [DATA_W-1:0]            s_wdata;
   logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
   logic [NUM_SLAVES-1:0]        s_ack;

   modport master (
      output m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
      input  m_rdata, m_ack, m_err, s_sel, s_we, s_addr, s_wdata
   );

   modport slave (
      input  m_req, m_we, m_addr, m_wdata, s_rdata, s_ack,
      output m_rdata, m_ack, m_err, s_sel, s_we, s_addr, s_wdata
   );
endinterface

// File: rtl/bus_decoder_fsm.sv
// ---------------------------------------------------------------------------
// bus_decoder_fsm
//   Registered memory-map decoder between the core data port and
//   NUM_SLAVES memory-mapped devices. Each request is decoded against
//   inclusive per-slave windows, a one-hot chip select with a slave-relative
//   word address is driven, and the decoder waits for that slave's ack with
//   a timeout. Unmapped addresses and timeouts return an error response.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   bus       --   bus_decoder_fsm_if.slave (m_* request/response, s_* select)
//   err_count out  saturating count of error responses
// ---------------------------------------------------------------------------
module bus_decoder_fsm #(
   parameter int                           NUM_SLAVES = 3,
   parameter int                           ADDR_W     = 32,
   parameter int                           DATA_W     = 32,
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = {32'h1001_002C, 32'h1001_0024, 32'h1001_0000},
   parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_LAST   = {32'h1001_003F, 32'h1001_002B, 32'h1001_0023},
   parameter int                           TIMEOUT    = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bus_decoder_fsm_if.slave     bus,
   output logic [7:0]           err_count
);

   localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [CNT_W-1:0]   cnt;

   // -------------------------------------------------------------------------
   // Address decode. Scanning from the top index down lets the lowest
   // matching window overwrite the others, so overlaps resolve to the
   // lowest index.
   // -------------------------------------------------------------------------
   logic               hit;
   logic [IDX_W-1:0]   hit_idx;
   logic [ADDR_W-1:0]  hit_waddr;

   always_comb begin
      hit       = 1'b0;
      hit_idx   = '0;
      hit_waddr = '0;
      for (int i = NUM_SLAVES-1; i >= 0; i--) begin
         if ((bus.m_addr >= SLV_BASE[i*ADDR_W +: ADDR_W]) &&
             (bus.m_addr <= SLV_LAST[i*ADDR_W +: ADDR_W])) begin
            hit       = 1'b1;
            hit_idx   = IDX_W'(i);
            hit_waddr = (bus.m_addr - SLV_BASE[i*ADDR_W +: ADDR_W]) >> 2;
         end
      end
   end

   // Ack and read data of the latched slave only; other acks are ignored.
   logic               sel_ack;
   logic [DATA_W-1:0]  sel_rdata;

   always_comb begin
      sel_ack   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx == IDX_W'(i)) begin
            sel_ack   = bus.s_ack[i];
            sel_rdata = bus.s_rdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Control FSM; every output is a register.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         cnt         <= '0;
         bus.m_rdata <= '0;
         bus.m_ack   <= 1'b0;
         bus.m_err   <= 1'b0;
         bus.s_sel   <= '0;
         bus.s_we    <= 1'b0;
         bus.s_addr  <= '0;
         bus.s_wdata <= '0;
         err_count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.m_ack   <= 1'b0;
               bus.m_err   <= 1'b0;
               bus.m_rdata <= '0;
               if (bus.m_req) begin
                  if (hit) begin
                     idx         <= hit_idx;
                     bus.s_addr  <= hit_waddr;
                     bus.s_we    <= bus.m_we;
                     bus.s_wdata <= bus.m_wdata;
                     bus.s_sel   <= NUM_SLAVES'(1) << hit_idx;
                     cnt         <= '0;
                     state       <= ACCESS;
                  end else begin
                     // unmapped: answer straight away, never touch a slave
                     bus.m_ack <= 1'b1;
                     bus.m_err <= 1'b1;
                     state     <= RESP;
                  end
               end
            end

            ACCESS: begin
               // ack is tested before expiry so a last-cycle ack still wins
               if (sel_ack) begin
                  bus.m_rdata <= bus.s_we ? '0 : sel_rdata;
                  bus.m_err   <= 1'b0;
                  bus.m_ack   <= 1'b1;
                  bus.s_sel   <= '0;
                  bus.s_we    <= 1'b0;
                  state       <= RESP;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  bus.m_rdata <= '0;
                  bus.m_err   <= 1'b1;
                  bus.m_ack   <= 1'b1;
                  bus.s_sel   <= '0;
                  bus.s_we    <= 1'b0;
                  state       <= RESP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            RESP: begin
               bus.m_ack   <= 1'b0;
               bus.m_err   <= 1'b0;
               bus.m_rdata <= '0;
               if (bus.m_err && (err_count != 8'hFF))
                  err_count <= err_count + 8'd1;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
